// File: rtl/instr_register_param_pkg.sv
// Shared types for the parametrised instruction register.
package instr_register_param_pkg;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;
endpackage

// File: rtl/instr_register_param_if.sv
// Driver/checker-facing bus of the instruction register.
interface instr_register_param_if
  import instr_register_param_pkg::*;
#(
  parameter int OP_W  = 32,
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  logic                   load_en;
  opcode_t                opcode;
  logic signed [OP_W-1:0] operand_a;
  logic signed [OP_W-1:0] operand_b;
  logic [AW-1:0]          write_pointer;
  logic [AW-1:0]          read_pointer;
  logic                   read_en;
  logic [3+4*OP_W:0]      instruction_word;
  logic                   instr_valid;
  logic                   div_err;
  logic                   full;
  logic                   empty;
  logic [AW:0]            count;

  modport master (
    output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer, read_en,
    input  instruction_word, instr_valid, div_err, full, empty, count
  );
  modport slave (
    input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer, read_en,
    output instruction_word, instr_valid, div_err, full, empty, count
  );
endinterface

// File: rtl/instr_register_param_alu.sv
// Combinational signed ALU producing a double-width result and an error flag.
module instr_alu
  import instr_register_param_pkg::*;
#(
  parameter int OP_W = 32
) (
  input  opcode_t                  opcode,
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic signed [2*OP_W-1:0] result,
  output logic                     err
);
  localparam int RW = 2*OP_W;

  logic signed [RW-1:0] ax, bx, bsafe;
  logic                 bz;

  // Work at double width so MULT keeps the full product and MIN/-1 cannot overflow.
  assign ax    = {{OP_W{a[OP_W-1]}}, a};
  assign bx    = {{OP_W{b[OP_W-1]}}, b};
  assign bz    = (b == '0);
  assign bsafe = bz ? RW'(1) : bx;

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = ax;
      PASSB: result = bx;
      ADD:   result = ax + bx;
      SUB:   result = ax - bx;
      MULT:  result = ax * bx;
      DIV:   if (bz) err = 1'b1; else result = ax / bsafe;
      MOD:   if (bz) err = 1'b1; else result = ax % bsafe;
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/instr_register_param.sv
// Instruction register with pointer or FIFO addressing and a registered read port.
module instr_register_param
  import instr_register_param_pkg::*;
#(
  parameter int OP_W      = 32,
  parameter int DEPTH     = 32,
  parameter bit FIFO_MODE = 1'b0
) (
  input logic                  clk,
  input logic                  reset_n,
  instr_register_param_if.slave bus
);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              RW       = 2*OP_W;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    opcode_t                opcode;
    logic signed [OP_W-1:0] a;
    logic signed [OP_W-1:0] b;
    logic signed [RW-1:0]   result;
    logic                   err;
  } entry_t;

  entry_t              mem [DEPTH];
  logic [DEPTH-1:0]    vld;
  logic [AW-1:0]       wp, rp, waddr, raddr;
  logic [AW:0]         cnt;
  logic                full_i, empty_i, do_wr, do_rd;
  logic signed [RW-1:0] alu_res;
  logic                alu_err;
  logic [3+4*OP_W:0]   word_q;
  logic                valid_q, err_q;

  instr_alu #(.OP_W(OP_W)) u_alu (
    .opcode (bus.opcode),
    .a      (bus.operand_a),
    .b      (bus.operand_b),
    .result (alu_res),
    .err    (alu_err)
  );

  // Full blocks the push and empty blocks the pop, so simultaneous push+pop degrade cleanly.
  always_comb begin
    full_i  = FIFO_MODE && (cnt == FULL_CNT);
    empty_i = FIFO_MODE && (cnt == '0);
    if (FIFO_MODE) begin
      do_wr = bus.load_en && !full_i;
      do_rd = bus.read_en && !empty_i;
      waddr = wp;
      raddr = rp;
    end else begin
      do_wr = bus.load_en;
      do_rd = bus.read_en;
      waddr = bus.write_pointer;
      raddr = bus.read_pointer;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld <= '0;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (FIFO_MODE && do_rd) vld[raddr] <= 1'b0;
      if (do_wr) begin
        mem[waddr] <= '{opcode: bus.opcode, a: bus.operand_a, b: bus.operand_b,
                        result: alu_res, err: alu_err};
        vld[waddr] <= 1'b1;
      end
      if (FIFO_MODE) begin
        if (do_wr) wp <= wp + AW'(1);
        if (do_rd) rp <= rp + AW'(1);
        cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
    end
  end

  // Read port samples the pre-write contents, giving read-before-write on address clashes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (do_rd) begin
      word_q  <= {mem[raddr].opcode, mem[raddr].a, mem[raddr].b, mem[raddr].result};
      valid_q <= vld[raddr];
      err_q   <= mem[raddr].err;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign bus.instruction_word = word_q;
  assign bus.instr_valid      = valid_q;
  assign bus.div_err          = err_q;
  assign bus.full             = full_i;
  assign bus.empty            = empty_i;
  assign bus.count            = FIFO_MODE ? cnt : '0;
endmodule

// File: tb/tb_instr_register_param.sv
// Directed bench: pointer-mode ALU vector table plus FIFO corner-case sequences.
module tb_instr_register_param;
  import instr_register_param_pkg::*;

  typedef logic [131:0] word_t;
  typedef struct {
    opcode_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  addr;
    logic [63:0] res;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  vec_t vt [16];

  always #5 clk = ~clk;

  instr_register_param_if #(.OP_W(32), .DEPTH(32)) pif ();
  instr_register_param_if #(.OP_W(32), .DEPTH(4))  fif ();

  instr_register_param #(.OP_W(32), .DEPTH(32), .FIFO_MODE(1'b0)) u_ptr (
    .clk(clk), .reset_n(reset_n), .bus(pif.slave));
  instr_register_param #(.OP_W(32), .DEPTH(4), .FIFO_MODE(1'b1)) u_fifo (
    .clk(clk), .reset_n(reset_n), .bus(fif.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic word_t fw(input logic [31:0] a);
    return {PASSA, a, 32'h0, 32'h0, a};
  endfunction

  task automatic fcyc(input logic push, input logic pop, input logic [31:0] a);
    fif.load_en   = push;
    fif.read_en   = pop;
    fif.opcode    = PASSA;
    fif.operand_a = a;
    fif.operand_b = '0;
    tick();
    fif.load_en = 1'b0;
    fif.read_en = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [31:0] a, input int exp_cnt);
    fcyc(1'b0, 1'b1, 32'h0);
    chk({name, " word"}, fif.instruction_word, fw(a));
    chk({name, " valid"}, word_t'(fif.instr_valid), word_t'(1));
    chk({name, " count"}, word_t'(fif.count), word_t'(exp_cnt));
  endtask

  task automatic pwrite(input logic [4:0] addr, input opcode_t op,
                        input logic [31:0] a, input logic [31:0] b);
    pif.load_en = 1'b1; pif.write_pointer = addr;
    pif.opcode = op; pif.operand_a = a; pif.operand_b = b;
    tick();
    pif.load_en = 1'b0;
  endtask

  task automatic pread(input logic [4:0] addr);
    pif.read_en = 1'b1; pif.read_pointer = addr;
    tick();
    pif.read_en = 1'b0;
  endtask

  initial begin
    vt[0]  = '{ADD,   32'd5,         32'hFFFF_FFF9, 5'd3,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vt[1]  = '{DIV,   32'hFFFF_FFF9, 32'd2,         5'd4,  64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vt[2]  = '{MOD,   32'hFFFF_FFF9, 32'd2,         5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[3]  = '{DIV,   32'd9,         32'd0,         5'd6,  64'h0,                   1'b1};
    vt[4]  = '{opcode_t'(4'hA), 32'd1, 32'd2,       5'd8,  64'h0,                   1'b1};
    vt[5]  = '{MULT,  32'h7FFF_FFFF, 32'd2,         5'd9,  64'h0000_0000_FFFF_FFFE, 1'b0};
    vt[6]  = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 64'h1,                   1'b0};
    vt[7]  = '{SUB,   32'd3,         32'd10,        5'd11, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0};
    vt[8]  = '{PASSA, 32'hFFFF_FFFC, 32'd0,         5'd12, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vt[9]  = '{PASSB, 32'd0,         32'h8000_0000, 5'd13, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vt[10] = '{ZERO,  32'd12,        32'd34,        5'd14, 64'h0,                   1'b0};
    vt[11] = '{MOD,   32'd7,         32'd0,         5'd15, 64'h0,                   1'b1};
    vt[12] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 64'h0000_0000_8000_0000, 1'b0};
    vt[13] = '{MOD,   32'd7,         32'hFFFF_FFFD, 5'd17, 64'h1,                   1'b0};
    vt[14] = '{ADD,   32'd1,         32'd1,         5'd31, 64'h2,                   1'b0};
    vt[15] = '{opcode_t'(4'hF), 32'd0, 32'd0,       5'd0,  64'h0,                   1'b1};

    pif.load_en = 0; pif.read_en = 0; pif.opcode = ZERO; pif.operand_a = 0; pif.operand_b = 0;
    pif.write_pointer = 0; pif.read_pointer = 0;
    fif.load_en = 0; fif.read_en = 0; fif.opcode = ZERO; fif.operand_a = 0; fif.operand_b = 0;
    fif.write_pointer = 0; fif.read_pointer = 0;

    // Reset state
    repeat (2) tick();
    chk("rst ptr word", pif.instruction_word, '0);
    chk("rst ptr valid", word_t'(pif.instr_valid), '0);
    chk("rst ptr err", word_t'(pif.div_err), '0);
    chk("rst ptr empty", word_t'(pif.empty), '0);
    chk("rst fifo count", word_t'(fif.count), '0);
    chk("rst fifo empty", word_t'(fif.empty), word_t'(1));
    chk("rst fifo full", word_t'(fif.full), '0);
    reset_n = 1'b1;
    tick();

    // Async reset mid-stream with count=3 and a valid word showing
    for (int k = 1; k <= 4; k++) fcyc(1'b1, 1'b0, 32'(k));
    pop_chk("t1 pop", 32'd1, 3);
    reset_n = 1'b0;
    #1;
    chk("t1 rst valid", word_t'(fif.instr_valid), '0);
    chk("t1 rst count", word_t'(fif.count), '0);
    chk("t1 rst empty", word_t'(fif.empty), word_t'(1));
    chk("t1 rst word", fif.instruction_word, '0);
    tick();
    reset_n = 1'b1;
    tick();
    fcyc(1'b0, 1'b1, 32'h0);
    chk("t1 pop after rst valid", word_t'(fif.instr_valid), '0);
    chk("t1 pop after rst empty", word_t'(fif.empty), word_t'(1));

    // Pointer-mode ALU table
    for (int i = 0; i < 16; i++) begin
      pwrite(vt[i].addr, vt[i].op, vt[i].a, vt[i].b);
      pread(vt[i].addr);
      chk($sformatf("vec%0d word", i), pif.instruction_word, {vt[i].op, vt[i].a, vt[i].b, vt[i].res});
      chk($sformatf("vec%0d valid", i), word_t'(pif.instr_valid), word_t'(1));
      chk($sformatf("vec%0d err", i), word_t'(pif.div_err), word_t'(vt[i].err));
    end

    // Read-before-write on the same address, then hold with read_en=0
    pwrite(5'd7, PASSA, 32'd100, 32'd0);
    pif.load_en = 1'b1; pif.write_pointer = 5'd7; pif.operand_a = 32'd200; pif.opcode = PASSA;
    pif.operand_b = 32'd0; pif.read_en = 1'b1; pif.read_pointer = 5'd7;
    tick();
    pif.load_en = 1'b0; pif.read_en = 1'b0;
    chk("rbw old", pif.instruction_word, fw(32'd100));
    pread(5'd7);
    chk("rbw new", pif.instruction_word, fw(32'd200));
    tick();
    chk("idle valid", word_t'(pif.instr_valid), '0);
    chk("idle hold", pif.instruction_word, fw(32'd200));
    pread(5'd25);
    chk("unwritten valid", word_t'(pif.instr_valid), '0);

    // FIFO fill past full, then drain past empty
    for (int k = 1; k <= 5; k++) begin
      fcyc(1'b1, 1'b0, 32'(k));
      if (k >= 4) begin
        chk($sformatf("t5 push%0d full", k), word_t'(fif.full), word_t'(1));
        chk($sformatf("t5 push%0d count", k), word_t'(fif.count), word_t'(4));
      end
    end
    for (int k = 1; k <= 4; k++) pop_chk($sformatf("t5 pop%0d", k), 32'(k), 4 - k);
    fcyc(1'b0, 1'b1, 32'h0);
    chk("t5 pop5 valid", word_t'(fif.instr_valid), '0);
    chk("t5 pop5 empty", word_t'(fif.empty), word_t'(1));
    chk("t5 pop5 hold", fif.instruction_word, fw(32'd4));

    // Move rp to 3, leave two entries, then push+pop across the wrap
    for (int k = 10; k <= 12; k++) fcyc(1'b1, 1'b0, 32'(k));
    for (int k = 10; k <= 12; k++) pop_chk($sformatf("t6 pre%0d", k), 32'(k), 12 - k);
    fcyc(1'b1, 1'b0, 32'd20);
    fcyc(1'b1, 1'b0, 32'd21);
    for (int j = 0; j < 3; j++) begin
      fcyc(1'b1, 1'b1, 32'(22 + j));
      chk($sformatf("t6 pp%0d word", j), fif.instruction_word, fw(32'(20 + j)));
      chk($sformatf("t6 pp%0d count", j), word_t'(fif.count), word_t'(2));
    end
    pop_chk("t6 tail23", 32'd23, 1);
    pop_chk("t6 tail24", 32'd24, 0);

    // Push+pop on empty: only the push lands
    fcyc(1'b1, 1'b1, 32'd30);
    chk("empty pp valid", word_t'(fif.instr_valid), '0);
    chk("empty pp count", word_t'(fif.count), word_t'(1));
    pop_chk("empty pp drain", 32'd30, 0);

    // Push+pop on full: only the pop lands
    for (int k = 40; k <= 43; k++) fcyc(1'b1, 1'b0, 32'(k));
    fcyc(1'b1, 1'b1, 32'd44);
    chk("full pp word", fif.instruction_word, fw(32'd40));
    chk("full pp count", word_t'(fif.count), word_t'(3));
    chk("full pp full", word_t'(fif.full), '0);
    for (int k = 41; k <= 43; k++) pop_chk($sformatf("full drain%0d", k), 32'(k), 43 - k);
    fcyc(1'b0, 1'b1, 32'h0);
    chk("full drain end valid", word_t'(fif.instr_valid), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
